// File: rtl/board_pkg.sv
// Board-level constants and the per-channel debounce response record shared
// by the switch input path.
package board_pkg;

  localparam int CLK_HZ      = 25_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Debounced view of one switch channel; all fields are registered.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } db_rsp_t;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// One switch channel: 2-flop synchroniser, stable-time counter, debounced
// level and registered press/release strobes.
module debounce_filter
  import board_pkg::*;
#(
  parameter int LIMIT = 8,
  parameter int CNT_W = 3
) (
  input  logic    i_Clock,
  input  logic    i_Reset_n,
  input  logic    i_Pin,
  output db_rsp_t o_Rsp,
  output logic    o_Fall_d
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [1:0]       sync_q;
  logic             s;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  assign s = sync_q[1];

  // Counter only runs while the synced level disagrees with the debounced
  // one, and is cleared on the accepting cycle, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = s;
      cnt_d   = '0;
      press_d = s;
      rel_d   = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync_q  <= '0;
      state_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_Pin};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign o_Rsp    = '{level: state_q, rise: press_q, fall: rel_q};
  // Next-cycle release lets the parent flip its LED on the same edge.
  assign o_Fall_d = rel_d;

endmodule

// File: rtl/switch_debounce_toggle.sv
// NUM_SW independent debounced switch channels, each toggling its LED on
// every debounced release.
module switch_debounce_toggle
  import board_pkg::*;
#(
  parameter int NUM_SW         = 4,
  parameter int DEBOUNCE_LIMIT = ms_to_cycles(DEBOUNCE_MS)
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Sw_State,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic [NUM_SW-1:0] o_LED
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);

  db_rsp_t [NUM_SW-1:0] rsp;
  logic    [NUM_SW-1:0] fall_d;
  logic    [NUM_SW-1:0] led_q, led_d;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    debounce_filter #(
      .LIMIT (DEBOUNCE_LIMIT),
      .CNT_W (CNT_W)
    ) u_db (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .i_Pin     (i_Switch[g]),
      .o_Rsp     (rsp[g]),
      .o_Fall_d  (fall_d[g])
    );
    assign o_Sw_State[g] = rsp[g].level;
    assign o_Press[g]    = rsp[g].rise;
    assign o_Release[g]  = rsp[g].fall;
  end

  assign led_d = led_q ^ fall_d;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) led_q <= '0;
    else            led_q <= led_d;
  end

  assign o_LED = led_q;

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Directed and random stimulus for switch_debounce_toggle, checked every
// cycle against a sliding-window model of the debounce rules.
module tb_switch_debounce_toggle;

  localparam int N = 4;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw;
  logic [N-1:0] o_Sw_State, o_Press, o_Release, o_LED;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  switch_debounce_toggle #(.NUM_SW(N), .DEBOUNCE_LIMIT(L)) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_Switch   (sw),
    .o_Sw_State (o_Sw_State),
    .o_Press    (o_Press),
    .o_Release  (o_Release),
    .o_LED      (o_LED)
  );

  // Model: win[k] holds the pin as seen k+1 edges ago. A channel flips at an
  // edge when the L pin samples taken 2..L+1 edges earlier all disagree with
  // its current debounced level.
  logic [N-1:0] win [0:L];
  logic [N-1:0] m_state, m_press, m_rel, m_led, flip;

  always_comb begin
    flip = '1;
    for (int k = 1; k <= L; k++) flip = flip & (win[k] ^ m_state);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= L; k++) win[k] <= '0;
      m_state <= '0;
      m_press <= '0;
      m_rel   <= '0;
      m_led   <= '0;
    end else begin
      win[0] <= sw;
      for (int k = 1; k <= L; k++) win[k] <= win[k-1];
      m_state <= m_state ^ flip;
      m_press <= flip & ~m_state;
      m_rel   <= flip & m_state;
      m_led   <= m_led ^ (flip & m_state);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if ({o_Sw_State, o_Press, o_Release, o_LED} !== {m_state, m_press, m_rel, m_led}) begin
        n_err++;
        $display("FAIL model t=%0t state/press/rel/led got %h/%h/%h/%h expected %h/%h/%h/%h",
                 $time, o_Sw_State, o_Press, o_Release, o_LED, m_state, m_press, m_rel, m_led);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int all_outs();
    return int'({o_Sw_State, o_Press, o_Release, o_LED});
  endfunction

  int pc, rc, hi, t_p, t_r;

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    @(negedge clk);
    cmp_en = 1'b1;

    // Reset held while pins wiggle
    for (int i = 0; i < 6; i++) begin
      sw = N'($urandom);
      @(negedge clk);
    end
    chk("reset_outs", all_outs(), 0);
    sw    = '0;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_outs", all_outs(), 0);

    // Clean press on ch0
    sw[0] = 1'b1;
    repeat (9) @(negedge clk);
    chk("press_early", int'(o_Sw_State[0]), 0);
    @(negedge clk);
    chk("press_state", int'(o_Sw_State[0]), 1);
    chk("press_strobe", int'(o_Press[0]), 1);
    chk("press_led", int'(o_LED[0]), 0);
    @(negedge clk);
    chk("press_one_cycle", int'(o_Press[0]), 0);

    // Clean release on ch0
    sw[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("rel_early", int'(o_Release[0]), 0);
    chk("rel_led_early", int'(o_LED[0]), 0);
    @(negedge clk);
    chk("rel_strobe", int'(o_Release[0]), 1);
    chk("rel_led", int'(o_LED[0]), 1);
    chk("rel_state", int'(o_Sw_State[0]), 0);
    @(negedge clk);
    chk("rel_one_cycle", int'(o_Release[0]), 0);
    sw[0] = 1'b1;
    repeat (12) @(negedge clk);
    sw[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("led_second_toggle", int'(o_LED[0]), 0);

    // Bouncing ch1, then held high
    pc = 0; rc = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw[1] = ~sw[1];
      @(negedge clk);
      pc += int'(o_Press[1]);
      rc += int'(o_Release[1]);
    end
    sw[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      pc += int'(o_Press[1]);
      rc += int'(o_Release[1]);
      if (i == 9)  chk("bounce_pre", int'(o_Sw_State[1]), 0);
      if (i == 10) chk("bounce_lat", int'(o_Sw_State[1]), 1);
    end
    chk("bounce_npress", pc, 1);
    chk("bounce_nrel", rc, 0);

    // Threshold pulses on ch2
    sw[2] = 1'b1;
    repeat (7) @(negedge clk);
    sw[2] = 1'b0;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      hi += int'(o_Sw_State[2]);
    end
    chk("pulse7_ignored", hi, 0);
    sw[2] = 1'b1;
    t_p = -1; t_r = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 8) sw[2] = 1'b0;
      if (o_Press[2])   t_p = i;
      if (o_Release[2]) t_r = i;
    end
    chk("pulse8_press_at", t_p, 10);
    chk("pulse8_rel_at", t_r, 18);

    // All channels together, then async reset mid-count
    sw = '0;
    repeat (12) @(negedge clk);
    sw = '1;
    repeat (10) @(negedge clk);
    chk("conc_press", int'(o_Press), 'hF);
    repeat (3) @(negedge clk);
    sw = '0;
    repeat (12) @(negedge clk);
    sw[3] = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_clear", all_outs(), 0);
    @(negedge clk);
    chk("reset_no_strobe", all_outs(), 0);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    chk("held_pre", int'(o_Sw_State[3]), 0);
    @(negedge clk);
    chk("held_press", int'(o_Press[3]), 1);
    chk("held_led", int'(o_LED[3]), 0);

    // Random pin activity with one mid-run async reset
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 9) == 0) sw[c] = ~sw[c];
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
